input_p2s_converter: RTL
========================

# input_p2s_converter

Per-channel parallel-to-serial stage directly downstream of the HBM read path. It accepts full-width HBM read words (`dn_input_vld`/`dn_input_dat` of one input AXI channel) and delivers them to the butterfly engine as narrower slices under a ready/valid handshake. In bypass mode (`is_bypass_p2s`) it passes whole words unchanged. Because the HBM read side has no backpressure, the block buffers words in a small FIFO and flags overflow.

## Interface
- `DATA_WIDTH`, 256, HBM word width.
- `OUT_WIDTH`, 64, slice width; DATA_WIDTH must be an integer multiple; R = DATA_WIDTH/OUT_WIDTH.
- `FIFO_DEPTH`, 4, word buffer depth, power of two ≥ 2.

- `sys_clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse; latches `length` and `is_bypass_p2s`.
- `length` input 32: number of HBM words in this transfer.
- `is_bypass_p2s` input 1: 1 means whole-word output, 0 means slice output.
- `up_vld` input 1: HBM word valid; there is no ready.
- `up_dat` input DATA_WIDTH: HBM word.
- `dn_rdy` input 1: engine accepts a beat.
- `dn_vld` output 1: beat valid.
- `dn_dat` output DATA_WIDTH: beat data.
  - Serial mode: slice in [OUT_WIDTH-1:0], upper bits zero.
  - Bypass: full word.
- `dn_last` output 1: final beat of the transfer.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse at transfer completion.
- `overflow` output 1: sticky; set when a word was dropped.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs reset to 0, the FIFO is emptied, all counters are cleared and the state is IDLE.
- **IDLE**
  - `up_vld` is ignored.
  - On `start`:
    - latch `length` into `len_r` and bypass into `byp_r`;
    - clear `in_cnt`, `out_cnt`, `slice_idx` and `overflow`;
    - go to RUN, or to DONE if `length==0`.
- **RUN, push side**
  - When `up_vld` and `in_cnt < len_r`, write the word and increment `in_cnt` (32-bit).
  - When `in_cnt == len_r`, further `up_vld` is ignored: no write, no overflow.
- **Full FIFO**
  - A push with a simultaneous pop is accepted and the occupancy is unchanged.
  - A push without a pop drops the word and sets `overflow`. `in_cnt` still increments so the transfer terminates.
- **RUN, pop side**
  - `dn_vld` = FIFO not empty.
  - Serial mode: `dn_dat` = head word slice `slice_idx`, covering bits [slice_idx·OUT_WIDTH +: OUT_WIDTH]. Slice 0 (LSBs) goes first.
  - On `dn_vld && dn_rdy`, `slice_idx` increments. At R-1 it wraps to 0 and the head is popped.
  - Bypass: each handshake pops one word and `slice_idx` stays 0.
  - `out_cnt` counts popped words.
- **`dn_last`**: asserted with `dn_vld` when `out_cnt == len_r-1` and either bypass is set or `slice_idx == R-1`.
- **Transfer end**: the handshake of the `dn_last` beat moves the FSM to DONE. Dropped words never reach the output, so when overflow is set and `in_cnt == len_r` with the FIFO empty, the FSM also moves to DONE.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE.
- **`start` outside IDLE**: ignored.
- **Reset mid-transfer**: immediate return to IDLE and the FIFO contents are discarded.
- **Outputs while `dn_vld` = 0**: `dn_dat` holds the head slice value or 0; the bench treats it as don't-care.

## Timing
- **`start` to RUN**: `start` sampled at edge N gives `busy`=1 after edge N. `up_vld` is accepted from the cycle after N.
- **Input to output latency**: a word pushed at edge M into an empty FIFO gives `dn_vld`=1 in the cycle after M, combinationally from the FIFO head registers.
- **Throughput**:
  - Serial mode: one slice per cycle while `dn_rdy`=1, so sustained input is limited to one word every R cycles. Faster input fills the FIFO and then overflows.
  - Bypass: one word per cycle.
- **Handshake**: `dn_vld` must not drop while a beat is pending, and `dn_dat` must not change until that beat's handshake.
- **Completion**:
  - `done` rises the cycle after the final handshake edge.
  - `busy` falls one cycle after `done` rises.
  - For `length==0`, `done` pulses in the cycle after `start`.

## Test plan
- **Serial basic**: R=4, `length`=2, words W0 and W1 pushed back-to-back, `dn_rdy`=1.
  - Response: 8 beats, W0[63:0], W0[127:64] … W1[255:192].
  - `dn_last` on beat 8 only, `done` one cycle later, `overflow`=0.
- **Bypass**: `is_bypass_p2s`=1, `length`=3, three words with `up_vld` held 3 cycles, `dn_rdy`=1.
  - Response: 3 full-word beats, first `dn_vld` one cycle after the first push, `dn_last` on the third beat.
- **Backpressure**: serial mode, `dn_rdy` toggling 1,0,1,0.
  - Response: `dn_dat` stable while stalled, no slice skipped or repeated, order preserved.
- **Overflow**: serial mode, FIFO_DEPTH=4, `length`=8, `up_vld` high 8 consecutive cycles, `dn_rdy`=1.
  - Response: `overflow` is set and stays set until the next `start`.
  - Output words appear in order with gaps; no hang; `done` pulses.
- **Boundaries**:
  - `length`=0 gives a `done` pulse the next cycle and no `dn_vld`.
  - Extra `up_vld` after `length` words is ignored.
  - `start` during RUN has no effect.
- **Reset mid-transfer**: assert `rst_n`=0 for one cycle during beat 3 of 8.
  - Response: all outputs 0 immediately; a new `start` then runs a clean transfer with correct data.

Source files
------------

// File: rtl/input_p2s_converter.sv
// Parallel-to-serial stage behind the HBM read path: buffers full-width words in a
// small FIFO and hands them to the butterfly engine as OUT_WIDTH slices or whole words.
module input_p2s_converter #(
    parameter int DATA_WIDTH = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           length,
    input  logic                  is_bypass_p2s,
    input  logic                  up_vld,
    input  logic [DATA_WIDTH-1:0] up_dat,
    input  logic                  dn_rdy,
    output logic                  dn_vld,
    output logic [DATA_WIDTH-1:0] dn_dat,
    output logic                  dn_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int R  = DATA_WIDTH / OUT_WIDTH;
    localparam int SW = (R > 1) ? $clog2(R) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [SW-1:0] SLICE_LAST = SW'(R - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [31:0]           len_r, in_cnt, out_cnt;
    logic                  byp_r;
    logic [SW-1:0]         slice_idx;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] head;

    logic empty, full, last_slice, hs, pop, push_req, wr_en, drop;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign last_slice = byp_r || (slice_idx == SLICE_LAST);
    assign dn_vld     = (state == RUN) && !empty;
    assign hs         = dn_vld && dn_rdy;
    assign pop        = hs && last_slice;
    assign push_req   = (state == RUN) && up_vld && (in_cnt < len_r);
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign wr_en      = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign dn_last    = dn_vld && (out_cnt == len_r - 32'd1) && last_slice;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign head       = mem[rd_ptr];

    always_comb begin
        dn_dat = '0;
        if (dn_vld) begin
            if (byp_r) begin
                dn_dat = head;
            end else begin
                dn_dat[OUT_WIDTH-1:0] = head[int'(slice_idx)*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (length == 32'd0) ? DONE : RUN;
            RUN: begin
                if (hs && dn_last) begin
                    state_nxt = DONE;
                end else if (overflow && (in_cnt == len_r) && empty) begin
                    // Dropped words never produce a last beat, so end once everything left has drained.
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r     <= '0;
            byp_r     <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            slice_idx <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (state == IDLE && start) begin
            len_r     <= length;
            byp_r     <= is_bypass_p2s;
            in_cnt    <= '0;
            out_cnt   <= '0;
            slice_idx <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (state == RUN) begin
            if (push_req) in_cnt <= in_cnt + 32'd1;
            if (drop)     overflow <= 1'b1;
            if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
            if (hs) begin
                if (pop) begin
                    slice_idx <= '0;
                    rd_ptr    <= rd_ptr + 1'b1;
                    out_cnt   <= out_cnt + 32'd1;
                end else begin
                    slice_idx <= slice_idx + 1'b1;
                end
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_ptr] <= up_dat;
    end

endmodule
